// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/flush sequencer: next-PC selects, FSM states and
// stall-need levels, plus the register-match helper used by hazard detection.
package hazard_pkg;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_J   = 2'b10;
    localparam logic [1:0] PCSEL_JR  = 2'b11;

    typedef enum logic {
        StRun   = 1'b0,
        StStall = 1'b1
    } state_e;

    localparam logic [1:0] NEED_NONE = 2'd0;
    localparam logic [1:0] NEED_ONE  = 2'd1;
    localparam logic [1:0] NEED_TWO  = 2'd2;

    // r0 is hardwired zero and never creates a dependency.
    function automatic logic reg_match(input logic [4:0] wreg, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic rt_en);
        return (wreg != 5'd0) && ((wreg == rs) || (rt_en && (wreg == rt)));
    endfunction

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// Bundle of pipeline-state inputs and sequencing outputs for hazard_flush_ctrl.
// The slave modport is the controller; the master modport drives the pipeline fields.
interface hazard_flush_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             mem_busy;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_jump;
    logic             id_bne_taken;
    logic             id_jr;
    logic             id_br_use;
    logic             ex_memread;
    logic             ex_regwrite;
    logic [4:0]       ex_wreg;
    logic             mem_memread;
    logic [4:0]       mem_wreg;
    logic             clr_cnt;
    logic             pc_write;
    logic             ifid_write;
    logic             pipe_en;
    logic             if_flush;
    logic             id_flush;
    logic [1:0]       pc_sel;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  mem_busy, id_rs, id_rt, id_uses_rt, id_jump, id_bne_taken, id_jr, id_br_use,
        input  ex_memread, ex_regwrite, ex_wreg, mem_memread, mem_wreg, clr_cnt,
        output pc_write, ifid_write, pipe_en, if_flush, id_flush, pc_sel,
        output stall_cycles, flush_cnt
    );

    modport master (
        output mem_busy, id_rs, id_rt, id_uses_rt, id_jump, id_bne_taken, id_jr, id_br_use,
        output ex_memread, ex_regwrite, ex_wreg, mem_memread, mem_wreg, clr_cnt,
        input  pc_write, ifid_write, pipe_en, if_flush, id_flush, pc_sel,
        input  stall_cycles, flush_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational stall-need calculation: how many bubbles the ID instruction needs before
// its operands can be forwarded (0, 1 or 2).
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic       id_br_use_i,
    input  logic       ex_memread_i,
    input  logic       ex_regwrite_i,
    input  logic [4:0] ex_wreg_i,
    input  logic       mem_memread_i,
    input  logic [4:0] mem_wreg_i,
    output logic [1:0] new_need_o
);

    logic rt_en;
    logic ex_match;
    logic mem_match;

    assign rt_en     = id_uses_rt_i | id_br_use_i;
    assign ex_match  = reg_match(ex_wreg_i, id_rs_i, id_rt_i, rt_en);
    assign mem_match = reg_match(mem_wreg_i, id_rs_i, id_rt_i, rt_en);

    always_comb begin
        new_need_o = NEED_NONE;
        if (id_br_use_i && ex_regwrite_i && !ex_memread_i && ex_match) begin
            new_need_o = NEED_ONE;
        end
        if (id_br_use_i && mem_memread_i && mem_match) begin
            new_need_o = NEED_ONE;
        end
        // A branch consuming a load result in ID must wait for it to reach WB.
        if (ex_memread_i && ex_match) begin
            new_need_o = id_br_use_i ? NEED_TWO : NEED_ONE;
        end
    end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline sequencer: freeze > stall > redirect > normal, with Mealy control outputs and
// saturating bring-up counters for stall and redirect cycles.
module hazard_flush_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    hazard_flush_ctrl_if.slave  ctrl_io
);

    state_e           state_q, state_d;
    logic [1:0]       stall_rem_q, stall_rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [1:0]       new_need;
    logic             stall_ev;
    logic             flush_ev;
    logic             redirect;

    hazard_detect u_detect (
        .id_rs_i       (ctrl_io.id_rs),
        .id_rt_i       (ctrl_io.id_rt),
        .id_uses_rt_i  (ctrl_io.id_uses_rt),
        .id_br_use_i   (ctrl_io.id_br_use),
        .ex_memread_i  (ctrl_io.ex_memread),
        .ex_regwrite_i (ctrl_io.ex_regwrite),
        .ex_wreg_i     (ctrl_io.ex_wreg),
        .mem_memread_i (ctrl_io.mem_memread),
        .mem_wreg_i    (ctrl_io.mem_wreg),
        .new_need_o    (new_need)
    );

    assign redirect = ctrl_io.id_jump | ctrl_io.id_bne_taken | ctrl_io.id_jr;

    always_comb begin
        state_d            = state_q;
        stall_rem_d        = stall_rem_q;
        stall_ev           = 1'b0;
        flush_ev           = 1'b0;
        ctrl_io.pc_write   = 1'b1;
        ctrl_io.ifid_write = 1'b1;
        ctrl_io.pipe_en    = 1'b1;
        ctrl_io.if_flush   = 1'b0;
        ctrl_io.id_flush   = 1'b0;
        ctrl_io.pc_sel     = PCSEL_SEQ;

        if (!reset) begin
            ctrl_io.pc_write   = 1'b0;
            ctrl_io.ifid_write = 1'b0;
            ctrl_io.pipe_en    = 1'b0;
            ctrl_io.if_flush   = 1'b1;
            ctrl_io.id_flush   = 1'b1;
        end else if (ctrl_io.mem_busy) begin
            ctrl_io.pc_write   = 1'b0;
            ctrl_io.ifid_write = 1'b0;
            ctrl_io.pipe_en    = 1'b0;
        end else if ((state_q == StStall) || (new_need != NEED_NONE)) begin
            ctrl_io.pc_write   = 1'b0;
            ctrl_io.ifid_write = 1'b0;
            ctrl_io.id_flush   = 1'b1;
            stall_ev           = 1'b1;
            // Once stalling, the remaining count is authoritative; new_need is ignored.
            if (state_q == StStall) begin
                stall_rem_d = stall_rem_q - 2'd1;
                state_d     = (stall_rem_q == 2'd1) ? StRun : StStall;
            end else begin
                stall_rem_d = new_need - 2'd1;
                state_d     = (new_need > NEED_ONE) ? StStall : StRun;
            end
        end else if (redirect) begin
            ctrl_io.if_flush = 1'b1;
            ctrl_io.id_flush = ctrl_io.id_bne_taken | ctrl_io.id_jr;
            flush_ev         = 1'b1;
            if (ctrl_io.id_jr) begin
                ctrl_io.pc_sel = PCSEL_JR;
            end else if (ctrl_io.id_bne_taken) begin
                ctrl_io.pc_sel = PCSEL_BR;
            end else begin
                ctrl_io.pc_sel = PCSEL_J;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ctrl_io.clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_ev && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush_ev && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            stall_rem_q <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_rem_q <= stall_rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ctrl_io.stall_cycles = stall_cnt_q;
    assign ctrl_io.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed self-checking bench for hazard_flush_ctrl (4-bit counters to reach saturation).
module tb_hazard_flush_ctrl;

    localparam int unsigned CW = 4;

    // {pc_write, ifid_write, pipe_en, if_flush, id_flush, pc_sel}
    localparam logic [6:0] CTL_RST    = 7'b0001100;
    localparam logic [6:0] CTL_FREEZE = 7'b0000000;
    localparam logic [6:0] CTL_STALL  = 7'b0010100;
    localparam logic [6:0] CTL_NORMAL = 7'b1110000;
    localparam logic [6:0] CTL_BNE    = 7'b1111101;
    localparam logic [6:0] CTL_JR     = 7'b1111111;
    localparam logic [6:0] CTL_JUMP   = 7'b1111010;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passed = 0;
    logic [6:0] ctl;

    always #5 clk = ~clk;

    hazard_flush_ctrl_if #(.CNT_W(CW)) bus ();

    hazard_flush_ctrl #(.CNT_W(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .ctrl_io (bus)
    );

    assign ctl = {bus.pc_write, bus.ifid_write, bus.pipe_en, bus.if_flush, bus.id_flush,
                  bus.pc_sel};

    task automatic idle_inputs();
        bus.mem_busy = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0;
        bus.id_jump = 0; bus.id_bne_taken = 0; bus.id_jr = 0; bus.id_br_use = 0;
        bus.ex_memread = 0; bus.ex_regwrite = 0; bus.ex_wreg = 0;
        bus.mem_memread = 0; bus.mem_wreg = 0; bus.clr_cnt = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        idle_inputs();
        bus.clr_cnt = 1;
        next_cycle();
        bus.clr_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        idle_inputs();
        #2;
        checks++; if (ctl !== CTL_RST) $display("FAIL reset_ctl got %b want %b", ctl, CTL_RST);
        else passed++;
        checks++; if (bus.stall_cycles !== 4'd0 || bus.flush_cnt !== 4'd0)
            $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.stall_cycles, bus.flush_cnt);
        else passed++;
        next_cycle();
        reset = 1;
        bus.ex_memread = 1; bus.ex_wreg = 5; bus.id_rs = 5; bus.id_br_use = 1;
        #1;
        checks++; if (ctl !== CTL_STALL) $display("FAIL pre_rst_stall got %b want %b", ctl, CTL_STALL);
        else passed++;
        next_cycle();
        #2 reset = 0;
        #1;
        checks++; if (ctl !== CTL_RST) $display("FAIL midstall_rst got %b want %b", ctl, CTL_RST);
        else passed++;
        checks++; if (bus.stall_cycles !== 4'd0)
            $display("FAIL midstall_rst_cnt got %0d want 0", bus.stall_cycles);
        else passed++;
        idle_inputs();
        next_cycle();
        reset = 1;
        #1;
        checks++; if (ctl !== CTL_NORMAL) $display("FAIL post_rst got %b want %b", ctl, CTL_NORMAL);
        else passed++;
        next_cycle();
        checks++; if (ctl !== CTL_NORMAL || bus.stall_cycles !== 4'd0)
            $display("FAIL post_rst2 got %b/%0d want %b/0", ctl, bus.stall_cycles, CTL_NORMAL);
        else passed++;
    endtask

    task automatic test_match_rules();
        bus.ex_memread = 1; bus.ex_wreg = 0; bus.id_rs = 0;
        #1;
        checks++; if (ctl !== CTL_NORMAL) $display("FAIL r0_nomatch got %b want %b", ctl, CTL_NORMAL);
        else passed++;
        bus.ex_wreg = 5; bus.id_rs = 3; bus.id_rt = 5; bus.id_uses_rt = 0;
        #1;
        checks++; if (ctl !== CTL_NORMAL) $display("FAIL rt_unused got %b want %b", ctl, CTL_NORMAL);
        else passed++;
        bus.id_uses_rt = 1;
        #1;
        checks++; if (ctl !== CTL_STALL) $display("FAIL rt_used got %b want %b", ctl, CTL_STALL);
        else passed++;
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_load_use();
        clear_counters();
        bus.ex_memread = 1; bus.ex_wreg = 5; bus.id_rs = 5;
        #1;
        checks++; if (ctl !== CTL_STALL) $display("FAIL lu_stall got %b want %b", ctl, CTL_STALL);
        else passed++;
        next_cycle();
        bus.ex_memread = 0; bus.ex_wreg = 0; bus.mem_memread = 1; bus.mem_wreg = 5;
        #1;
        checks++; if (ctl !== CTL_NORMAL) $display("FAIL lu_resume got %b want %b", ctl, CTL_NORMAL);
        else passed++;
        next_cycle();
        checks++; if (bus.stall_cycles !== 4'd1)
            $display("FAIL lu_cnt got %0d want 1", bus.stall_cycles);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_bne_stall();
        clear_counters();
        bus.id_bne_taken = 1; bus.id_br_use = 1; bus.id_rt = 7;
        bus.ex_memread = 1; bus.ex_wreg = 7;
        #1;
        checks++; if (ctl !== CTL_STALL) $display("FAIL bne_stall1 got %b want %b", ctl, CTL_STALL);
        else passed++;
        next_cycle();
        bus.ex_memread = 0; bus.ex_wreg = 0; bus.mem_memread = 1; bus.mem_wreg = 7;
        #1;
        checks++; if (ctl !== CTL_STALL) $display("FAIL bne_stall2 got %b want %b", ctl, CTL_STALL);
        else passed++;
        next_cycle();
        bus.mem_memread = 0; bus.mem_wreg = 0;
        #1;
        checks++; if (ctl !== CTL_BNE) $display("FAIL bne_redir got %b want %b", ctl, CTL_BNE);
        else passed++;
        next_cycle();
        checks++; if (bus.flush_cnt !== 4'd1 || bus.stall_cycles !== 4'd2)
            $display("FAIL bne_cnt got %0d/%0d want 1/2", bus.flush_cnt, bus.stall_cycles);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_jr_jump();
        clear_counters();
        bus.id_jr = 1; bus.id_jump = 1;
        #1;
        checks++; if (ctl !== CTL_JR) $display("FAIL jr_jump got %b want %b", ctl, CTL_JR);
        else passed++;
        next_cycle();
        checks++; if (bus.flush_cnt !== 4'd1) $display("FAIL jr_cnt got %0d want 1", bus.flush_cnt);
        else passed++;
        bus.id_jr = 0;
        #1;
        checks++; if (ctl !== CTL_JUMP) $display("FAIL jump got %b want %b", ctl, CTL_JUMP);
        else passed++;
        next_cycle();
        checks++; if (bus.flush_cnt !== 4'd2) $display("FAIL jump_cnt got %0d want 2", bus.flush_cnt);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_freeze();
        clear_counters();
        bus.ex_memread = 1; bus.ex_wreg = 9; bus.id_rs = 9; bus.id_br_use = 1; bus.id_jr = 1;
        #1;
        checks++; if (ctl !== CTL_STALL) $display("FAIL frz_stall1 got %b want %b", ctl, CTL_STALL);
        else passed++;
        next_cycle();
        bus.mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (ctl !== CTL_FREEZE)
                $display("FAIL frz_%0d got %b want %b", i, ctl, CTL_FREEZE);
            else passed++;
            next_cycle();
        end
        checks++; if (bus.stall_cycles !== 4'd1)
            $display("FAIL frz_hold_cnt got %0d want 1", bus.stall_cycles);
        else passed++;
        bus.mem_busy = 0; bus.ex_memread = 0; bus.ex_wreg = 0;
        #1;
        checks++; if (ctl !== CTL_STALL) $display("FAIL frz_stall2 got %b want %b", ctl, CTL_STALL);
        else passed++;
        next_cycle();
        checks++; if (ctl !== CTL_JR) $display("FAIL frz_jr got %b want %b", ctl, CTL_JR);
        else passed++;
        next_cycle();
        checks++; if (bus.stall_cycles !== 4'd2 || bus.flush_cnt !== 4'd1)
            $display("FAIL frz_cnt got %0d/%0d want 2/1", bus.stall_cycles, bus.flush_cnt);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_saturate();
        clear_counters();
        bus.ex_memread = 1; bus.ex_wreg = 4; bus.id_rs = 4;
        for (int i = 0; i < 20; i++) next_cycle();
        checks++; if (bus.stall_cycles !== 4'd15)
            $display("FAIL sat_cnt got %0d want 15", bus.stall_cycles);
        else passed++;
        next_cycle();
        checks++; if (bus.stall_cycles !== 4'd15)
            $display("FAIL sat_hold got %0d want 15", bus.stall_cycles);
        else passed++;
        bus.clr_cnt = 1;
        #1;
        checks++; if (ctl !== CTL_STALL) $display("FAIL clr_stall got %b want %b", ctl, CTL_STALL);
        else passed++;
        next_cycle();
        checks++; if (bus.stall_cycles !== 4'd0)
            $display("FAIL clr_cnt got %0d want 0", bus.stall_cycles);
        else passed++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_match_rules();
        test_load_use();
        test_bne_stall();
        test_jr_jump();
        test_freeze();
        test_saturate();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
